pipeline_debug_sequencer: RTL and testbench

//  Debug controller between the UART rx/tx blocks and the MIPS pipeline.
//  - Decodes single-byte host commands: run, step, dump, pause.
//  - Gates pipeline advance via a clock enable.
//  - On step-complete or halt, streams NUM_WORDS 32-bit pipeline words
//    (PC_sumado_IF, latch contents, ...) out over UART, MSB byte first.

---
 rtl/pipeline_debug_sequencer.sv | 138 +++++++++++++
 tb/tb_pipeline_debug_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_sequencer.sv
// Host-driven debug controller: decodes UART command bytes, gates the MIPS
// pipeline clock enable, and streams pipeline state words back MSB byte first.
module pipeline_debug_sequencer #(
    parameter int         NUM_WORDS = 8,
    parameter int         WSEL_W    = 3,
    parameter logic [7:0] CMD_RUN   = 8'h63,
    parameter logic [7:0] CMD_STEP  = 8'h73,
    parameter logic [7:0] CMD_DUMP  = 8'h64,
    parameter logic [7:0] CMD_PAUSE = 8'h70
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              halt,
    input  logic [31:0]       dump_word,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              pipe_en,
    output logic [WSEL_W-1:0] word_sel,
    output logic [31:0]       cycle_count,
    output logic              halted,
    output logic              dbg_idle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_LOAD,
        S_SEND,
        S_WAIT
    } state_t;

    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(NUM_WORDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] shreg;
    logic [1:0]  byte_cnt;
    logic [7:0]  tx_data_q;

    assign dbg_idle = (state == S_IDLE);

    always_comb begin
        state_nxt = state;
        pipe_en   = 1'b0;
        tx_start  = 1'b0;
        tx_data   = tx_data_q;
        case (state)
            S_IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_RUN && !halted) begin
                        state_nxt = S_RUN;
                    end else if (rx_data == CMD_STEP && !halted) begin
                        state_nxt = S_STEP;
                    end else if (rx_data == CMD_DUMP) begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_RUN: begin
                pipe_en = 1'b1;
                // halt takes priority; both paths end in a dump anyway
                if (halt || (rx_done && rx_data == CMD_PAUSE)) begin
                    state_nxt = S_LOAD;
                end
            end
            S_STEP: begin
                pipe_en   = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                tx_data = shreg[31:24];
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (byte_cnt != 2'd3) begin
                        state_nxt = S_SEND;
                    end else if (word_sel == LAST_WORD) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= 32'd0;
            byte_cnt    <= 2'd0;
            word_sel    <= '0;
            cycle_count <= 32'd0;
            halted      <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            state     <= state_nxt;
            tx_data_q <= tx_data;
            if (pipe_en) begin
                cycle_count <= cycle_count + 32'd1;
                if (halt) begin
                    halted <= 1'b1;
                end
            end
            // every dump entered from a command or a halt starts at word 0
            if ((state == S_IDLE || state == S_RUN || state == S_STEP) && state_nxt == S_LOAD) begin
                word_sel <= '0;
            end
            if (state == S_LOAD) begin
                shreg    <= dump_word;
                byte_cnt <= 2'd0;
            end
            if (state == S_WAIT && tx_done) begin
                shreg    <= {shreg[23:0], 8'd0};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word_sel <= (word_sel == LAST_WORD) ? '0 : word_sel + WSEL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_debug_sequencer.sv
// Self-checking bench for pipeline_debug_sequencer: directed command sequence with
// randomized dump contents and run lengths, checked against a byte-stream model.
module tb_pipeline_debug_sequencer;

    localparam int         NW        = 8;
    localparam logic [7:0] CMD_RUN   = 8'h63;
    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] CMD_PAUSE = 8'h70;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_busy;
    logic        tx_done;
    logic        halt;
    logic [31:0] dump_word;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        pipe_en;
    logic [2:0]  word_sel;
    logic [31:0] cycle_count;
    logic        halted;
    logic        dbg_idle;

    logic [31:0] words [NW];
    logic [7:0]  rx_q [$];
    int          vectors;
    int          miscompares;
    int          starts;
    int          pipe_cycles;
    int          resp_cnt;
    logic        busy_r;
    logic        done_r;
    logic        force_busy;
    int          exp_cc;
    logic        exp_halted;

    pipeline_debug_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .halt       (halt),
        .dump_word  (dump_word),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .pipe_en    (pipe_en),
        .word_sel   (word_sel),
        .cycle_count(cycle_count),
        .halted     (halted),
        .dbg_idle   (dbg_idle)
    );

    assign dump_word = words[word_sel];

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: present inputs, sample outputs mid-cycle, emulate the UART
    // transmitter (busy after a start, tx_done two cycles after tx_start).
    task automatic tick();
        tx_busy = busy_r | force_busy;
        tx_done = done_r;
        #1;
        if (tx_start) begin
            rx_q.push_back(tx_data);
            starts++;
        end
        if (pipe_en) pipe_cycles++;
        if (reset) begin
            busy_r   = 1'b0;
            done_r   = 1'b0;
            resp_cnt = 0;
        end else begin
            if (done_r) begin
                done_r = 1'b0;
                busy_r = 1'b0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) done_r = 1'b1;
            end
            if (tx_start) begin
                busy_r   = 1'b1;
                resp_cnt = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic fill_words(input logic rnd);
        for (int i = 0; i < NW; i++) begin
            words[i] = rnd ? $urandom : 32'h0400_0000 + 32'(i);
        end
    endtask

    task automatic check_status(input string tag);
        checkOutput({tag, "_cycle_count"}, cycle_count, 32'(exp_cc));
        checkOutput({tag, "_halted"}, {31'b0, halted}, {31'b0, exp_halted});
    endtask

    // Runs a dump to completion from LOAD; optionally injects a host byte mid-dump.
    task automatic wait_dump(input string tag, input int inject_at, input logic [7:0] inj);
        int   p0;
        logic done;
        logic [31:0] obs;
        logic [31:0] exp;
        p0   = pipe_cycles;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (i == inject_at) begin
                rx_data = inj;
                rx_done = 1'b1;
            end
            tick();
            rx_done = 1'b0;
            if (dbg_idle) done = 1'b1;
        end
        checkOutput({tag, "_finished"}, {31'b0, done}, 32'd1);
        checkOutput({tag, "_byte_count"}, 32'(rx_q.size()), 32'(4 * NW));
        for (int i = 0; i < 4 * NW; i++) begin
            exp = {24'b0, 8'(words[i / 4] >> (8 * (3 - (i % 4))))};
            obs = (i < rx_q.size()) ? {24'b0, rx_q[i]} : 32'hxxxx_xxxx;
            checkOutput($sformatf("%s_byte%0d", tag, i), obs, exp);
        end
        checkOutput({tag, "_no_pipe_en"}, 32'(pipe_cycles - p0), 32'd0);
        checkOutput({tag, "_word_sel_end"}, {29'b0, word_sel}, 32'd0);
        rx_q.delete();
    endtask

    task automatic do_step(input string tag, input int inject_at, input logic [7:0] inj);
        int p0;
        p0 = pipe_cycles;
        applyStimulus(CMD_STEP);
        tick();
        exp_cc++;
        checkOutput({tag, "_pipe_cycles"}, 32'(pipe_cycles - p0), 32'd1);
        check_status(tag);
        wait_dump(tag, inject_at, inj);
    endtask

    task automatic do_run_pause(input string tag, input int k);
        int p0;
        p0 = pipe_cycles;
        fill_words(1'b1);
        applyStimulus(CMD_RUN);
        repeat (k) tick();
        applyStimulus(CMD_PAUSE);
        exp_cc += k + 1;
        checkOutput({tag, "_pipe_cycles"}, 32'(pipe_cycles - p0), 32'(k + 1));
        check_status(tag);
        wait_dump(tag, -1, 8'h00);
    endtask

    initial begin
        int p0;
        int s0;
        int k;
        vectors     = 0;
        miscompares = 0;
        starts      = 0;
        pipe_cycles = 0;
        resp_cnt    = 0;
        busy_r      = 1'b0;
        done_r      = 1'b0;
        force_busy  = 1'b0;
        exp_cc      = 0;
        exp_halted  = 1'b0;
        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_done     = 1'b0;
        tx_busy     = 1'b0;
        tx_done     = 1'b0;
        halt        = 1'b0;
        fill_words(1'b0);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_dbg_idle", {31'b0, dbg_idle}, 32'd1);
        checkOutput("reset_tx_start", {31'b0, tx_start}, 32'd0);
        checkOutput("reset_pipe_en", {31'b0, pipe_en}, 32'd0);
        checkOutput("reset_tx_data", {24'b0, tx_data}, 32'd0);
        checkOutput("reset_word_sel", {29'b0, word_sel}, 32'd0);
        check_status("reset");

        $display("[TB] plain dump of 0x0400_000n words");
        applyStimulus(CMD_DUMP);
        wait_dump("dump1", -1, 8'h00);
        checkOutput("dump1_idle", {31'b0, dbg_idle}, 32'd1);

        $display("[TB] two single steps, second dump ignores a run byte");
        fill_words(1'b1);
        do_step("step1", -1, 8'h00);
        fill_words(1'b1);
        do_step("step2", 5, CMD_RUN);
        checkOutput("step_total", cycle_count, 32'd2);

        $display("[TB] run then pause, fixed and random lengths");
        do_run_pause("pause5", 5);
        for (int r = 0; r < 2; r++) begin
            k = $urandom_range(12, 1);
            do_run_pause($sformatf("pause_rnd%0d", r), k);
        end

        $display("[TB] transmitter busy on dump entry, stray byte mid-dump");
        fill_words(1'b1);
        force_busy = 1'b1;
        s0 = starts;
        applyStimulus(CMD_DUMP);
        repeat (20) tick();
        checkOutput("busy_no_start", 32'(starts - s0), 32'd0);
        force_busy = 1'b0;
        wait_dump("busy_dump", 7, 8'h78);

        $display("[TB] run until halt");
        fill_words(1'b1);
        p0 = pipe_cycles;
        applyStimulus(CMD_RUN);
        repeat (10) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        exp_cc += 11;
        exp_halted = 1'b1;
        checkOutput("halt_pipe_cycles", 32'(pipe_cycles - p0), 32'd11);
        check_status("halt");
        wait_dump("halt_dump", -1, 8'h00);
        p0 = pipe_cycles;
        applyStimulus(CMD_STEP);
        repeat (5) tick();
        applyStimulus(CMD_RUN);
        repeat (5) tick();
        checkOutput("halted_no_pipe", 32'(pipe_cycles - p0), 32'd0);
        checkOutput("halted_idle", {31'b0, dbg_idle}, 32'd1);
        check_status("halted");
        fill_words(1'b1);
        applyStimulus(CMD_DUMP);
        wait_dump("halted_dump", -1, 8'h00);

        $display("[TB] reset in the middle of a dump");
        fill_words(1'b1);
        s0 = starts;
        applyStimulus(CMD_DUMP);
        for (int i = 0; i < 200 && (starts - s0) < 5; i++) tick();
        checkOutput("mid_reset_5_bytes", 32'(starts - s0), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cc = 0;
        exp_halted = 1'b0;
        checkOutput("mid_reset_tx_start", {31'b0, tx_start}, 32'd0);
        checkOutput("mid_reset_word_sel", {29'b0, word_sel}, 32'd0);
        checkOutput("mid_reset_dbg_idle", {31'b0, dbg_idle}, 32'd1);
        checkOutput("mid_reset_pipe_en", {31'b0, pipe_en}, 32'd0);
        check_status("mid_reset");
        rx_q.delete();
        fill_words(1'b1);
        applyStimulus(CMD_DUMP);
        wait_dump("after_reset_dump", -1, 8'h00);
        do_step("after_reset_step", -1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
